// File: rtl/hazard_ctrl_md_if.sv
// Purpose : bundle of hazard-unit signals between the pipeline datapath and hazard_ctrl_md.
// Latency : pure wiring, no state.
// Backpr. : none; the stall output is the only throttle on the pipeline.
// Ports   : master = datapath side (drives stage info, receives stall/fwd/md status);
//           slave  = hazard unit side.
interface hazard_ctrl_md_if #(
  parameter int AW    = 5,
  parameter int TW    = 2,
  parameter int CNT_W = 32
);
  // stage information from the datapath
  logic [TW-1:0]    D_tuse_rs;
  logic [TW-1:0]    D_tuse_rt;
  logic [AW-1:0]    D_a1;
  logic [AW-1:0]    D_a2;
  logic [AW-1:0]    E_a1;
  logic [AW-1:0]    E_a2;
  logic [AW-1:0]    E_a3;
  logic [AW-1:0]    M_a3;
  logic [AW-1:0]    W_a3;
  logic             E_rfwr;
  logic             M_rfwr;
  logic             W_rfwr;
  logic [TW-1:0]    E_tnew;
  logic [TW-1:0]    M_tnew;
  logic [AW-1:0]    M_a2;
  logic             D_md_use;
  logic             E_md_start;
  logic             E_md_div;
  // control back to the datapath
  logic             stall;
  logic [1:0]       stall_cause;
  logic [1:0]       fwd_d_rs;
  logic [1:0]       fwd_d_rt;
  logic [1:0]       fwd_e_a;
  logic [1:0]       fwd_e_b;
  logic [1:0]       fwd_m_wd;
  logic             md_busy;
  logic             md_done;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_tuse_rs, D_tuse_rt, D_a1, D_a2, E_a1, E_a2, E_a3, M_a3, W_a3,
           E_rfwr, M_rfwr, W_rfwr, E_tnew, M_tnew, M_a2, D_md_use, E_md_start, E_md_div,
    input  stall, stall_cause, fwd_d_rs, fwd_d_rt, fwd_e_a, fwd_e_b, fwd_m_wd,
           md_busy, md_done, md_err, stall_cnt
  );

  modport slave (
    input  D_tuse_rs, D_tuse_rt, D_a1, D_a2, E_a1, E_a2, E_a3, M_a3, W_a3,
           E_rfwr, M_rfwr, W_rfwr, E_tnew, M_tnew, M_a2, D_md_use, E_md_start, E_md_div,
    output stall, stall_cause, fwd_d_rs, fwd_d_rt, fwd_e_a, fwd_e_b, fwd_m_wd,
           md_busy, md_done, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_md.sv
// Purpose : 5-stage MIPS hazard unit: Tuse/Tnew stall, priority forwarding selects,
//           mult/div busy tracking (md_busy/md_done/md_err) and a saturating stall counter.
// Latency : stall and fwd selects are combinational; md_cnt, md_err, stall_cnt update at posedge.
// Backpr. : stall freezes PC and F/D and bubbles D/E; nothing upstream can hold this block off.
// Ports   : clk, reset (synchronous, active-low); hz = hazard_ctrl_md_if.slave carrying
//           stage addresses/Tuse/Tnew/rfwr in and stall/stall_cause/fwd_*/md_*/stall_cnt out.
module hazard_ctrl_md #(
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_ctrl_md_if.slave      hz
);

  localparam int MDW = $clog2(DIV_LAT + 1);

  logic [MDW-1:0]   md_cnt;
  logic             md_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic data_stall;
  logic md_stall;
  logic md_busy_w;

  // A producer blocks a source when it writes that register and its result
  // arrives later than the consumer needs it. $zero never blocks.
  function automatic logic src_stall(
    input logic [AW-1:0] a,
    input logic [TW-1:0] tuse,
    input logic [AW-1:0] p_a3,
    input logic          p_rfwr,
    input logic [TW-1:0] p_tnew
  );
    return (a != '0) && (a == p_a3) && p_rfwr && (p_tnew > tuse);
  endfunction

  // Youngest ready producer wins; callers pass a zero ok-flag for producers
  // that are not candidates for that consumer stage.
  function automatic logic [1:0] fwd_pick(
    input logic [AW-1:0] a,
    input logic [AW-1:0] e_a3, input logic e_ok,
    input logic [AW-1:0] m_a3, input logic m_ok,
    input logic [AW-1:0] w_a3, input logic w_ok
  );
    if (a == '0)                  return 2'd0;
    else if (e_ok && a == e_a3)   return 2'd1;
    else if (m_ok && a == m_a3)   return 2'd2;
    else if (w_ok && a == w_a3)   return 2'd3;
    else                          return 2'd0;
  endfunction

  logic e_rdy, m_rdy;
  assign e_rdy = hz.E_rfwr && (hz.E_tnew == '0);
  assign m_rdy = hz.M_rfwr && (hz.M_tnew == '0);

  always_comb begin
    data_stall = src_stall(hz.D_a1, hz.D_tuse_rs, hz.E_a3, hz.E_rfwr, hz.E_tnew)
               | src_stall(hz.D_a1, hz.D_tuse_rs, hz.M_a3, hz.M_rfwr, hz.M_tnew)
               | src_stall(hz.D_a2, hz.D_tuse_rt, hz.E_a3, hz.E_rfwr, hz.E_tnew)
               | src_stall(hz.D_a2, hz.D_tuse_rt, hz.M_a3, hz.M_rfwr, hz.M_tnew);
  end

  assign md_busy_w = (md_cnt != '0);
  // A start in E this cycle already counts as busy for the dependent in D.
  assign md_stall  = hz.D_md_use && (md_busy_w || hz.E_md_start);

  assign hz.stall       = data_stall | md_stall;
  assign hz.stall_cause = {md_stall, data_stall};
  assign hz.md_busy     = md_busy_w;
  assign hz.md_done     = (md_cnt == MDW'(1));
  assign hz.md_err      = md_err_q;
  assign hz.stall_cnt   = stall_cnt_q;

  assign hz.fwd_d_rs = fwd_pick(hz.D_a1, hz.E_a3, e_rdy, hz.M_a3, m_rdy, hz.W_a3, hz.W_rfwr);
  assign hz.fwd_d_rt = fwd_pick(hz.D_a2, hz.E_a3, e_rdy, hz.M_a3, m_rdy, hz.W_a3, hz.W_rfwr);
  assign hz.fwd_e_a  = fwd_pick(hz.E_a1, hz.E_a3, 1'b0,  hz.M_a3, m_rdy, hz.W_a3, hz.W_rfwr);
  assign hz.fwd_e_b  = fwd_pick(hz.E_a2, hz.E_a3, 1'b0,  hz.M_a3, m_rdy, hz.W_a3, hz.W_rfwr);
  assign hz.fwd_m_wd = fwd_pick(hz.M_a2, hz.E_a3, 1'b0,  hz.M_a3, 1'b0,  hz.W_a3, hz.W_rfwr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt      <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (hz.E_md_start) begin
        // A start while busy restarts the unit and is flagged until reset.
        md_cnt <= hz.E_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
        if (md_busy_w) md_err_q <= 1'b1;
      end else if (md_busy_w) begin
        md_cnt <= md_cnt - MDW'(1);
      end

      if (hz.stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Purpose : directed self-checking bench for hazard_ctrl_md.
// Latency : inputs change 1ns after posedge, outputs sampled 1ns later.
// Backpr. : n/a.
module tb_hazard_ctrl_md;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  hazard_ctrl_md_if #(.AW(5), .TW(2), .CNT_W(32)) hif ();

  hazard_ctrl_md #(
    .AW(5), .TW(2), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_in();
    hif.D_tuse_rs = '0; hif.D_tuse_rt = '0;
    hif.D_a1 = '0; hif.D_a2 = '0; hif.E_a1 = '0; hif.E_a2 = '0;
    hif.E_a3 = '0; hif.M_a3 = '0; hif.W_a3 = '0; hif.M_a2 = '0;
    hif.E_rfwr = 1'b0; hif.M_rfwr = 1'b0; hif.W_rfwr = 1'b0;
    hif.E_tnew = '0; hif.M_tnew = '0;
    hif.D_md_use = 1'b0; hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    clr_in();

    // reset state
    step(); step();
    settle();
    chk("rst_stall",     32'(hif.stall),     0);
    chk("rst_md_busy",   32'(hif.md_busy),   0);
    chk("rst_md_done",   32'(hif.md_done),   0);
    chk("rst_md_err",    32'(hif.md_err),    0);
    chk("rst_stall_cnt", hif.stall_cnt,      0);
    reset = 1'b1;

    // 1: lw $1 in E, add rs=$1 in D with tuse=1
    step();
    hif.D_a1 = 5'd1; hif.D_tuse_rs = 2'd1;
    hif.E_a3 = 5'd1; hif.E_rfwr = 1'b1; hif.E_tnew = 2'd2;
    settle();
    chk("t1_stall",  32'(hif.stall),       1);
    chk("t1_cause",  32'(hif.stall_cause), 1);
    chk("t1_fwd_e",  32'(hif.fwd_d_rs),    0);
    step();
    hif.E_a3 = '0; hif.E_rfwr = 1'b0; hif.E_tnew = '0;
    hif.M_a3 = 5'd1; hif.M_rfwr = 1'b1; hif.M_tnew = '0;
    settle();
    chk("t1_unstall", 32'(hif.stall),    0);
    chk("t1_fwd_m",   32'(hif.fwd_d_rs), 2);
    chk("t1_cnt",     hif.stall_cnt,     1);

    // tnew == tuse boundary: no stall, no forward yet
    step(); clr_in();
    hif.D_a1 = 5'd7; hif.D_tuse_rs = 2'd1;
    hif.E_a3 = 5'd7; hif.E_rfwr = 1'b1; hif.E_tnew = 2'd1;
    settle();
    chk("eq_tnew_stall", 32'(hif.stall), 0);

    // M producer stalling rt
    step(); clr_in();
    hif.D_a2 = 5'd5; hif.D_tuse_rt = 2'd0;
    hif.M_a3 = 5'd5; hif.M_rfwr = 1'b1; hif.M_tnew = 2'd1;
    settle();
    chk("m_rt_stall", 32'(hif.stall), 1);
    chk("m_rt_fwd",   32'(hif.fwd_d_rt), 0);

    // 2: E wins over M
    step(); clr_in();
    hif.D_a1 = 5'd2; hif.D_tuse_rs = 2'd0;
    hif.E_a3 = 5'd2; hif.E_rfwr = 1'b1; hif.E_tnew = 2'd0;
    hif.M_a3 = 5'd2; hif.M_rfwr = 1'b1; hif.M_tnew = 2'd0;
    settle();
    chk("t2_stall", 32'(hif.stall),    0);
    chk("t2_fwd",   32'(hif.fwd_d_rs), 1);

    // 3: $zero never stalls or forwards
    step(); clr_in();
    hif.D_a1 = 5'd0; hif.D_tuse_rs = 2'd0;
    hif.E_a3 = 5'd0; hif.E_rfwr = 1'b1; hif.E_tnew = 2'd2;
    settle();
    chk("t3_stall", 32'(hif.stall),    0);
    chk("t3_fwd",   32'(hif.fwd_d_rs), 0);

    // E/M stage selects: W for E_a1, M beats W for E_a2, W only for store data
    step(); clr_in();
    hif.E_a1 = 5'd3; hif.E_a2 = 5'd4; hif.M_a2 = 5'd3;
    hif.E_a3 = 5'd3; hif.E_rfwr = 1'b1; hif.E_tnew = 2'd0;
    hif.M_a3 = 5'd4; hif.M_rfwr = 1'b1; hif.M_tnew = 2'd0;
    hif.W_a3 = 5'd3; hif.W_rfwr = 1'b1;
    settle();
    chk("fwd_e_a",  32'(hif.fwd_e_a),  3);
    chk("fwd_e_b",  32'(hif.fwd_e_b),  2);
    chk("fwd_m_wd", 32'(hif.fwd_m_wd), 3);
    hif.W_a3 = 5'd4;
    settle();
    chk("fwd_e_b_mw", 32'(hif.fwd_e_b), 2);
    chk("fwd_e_a_no", 32'(hif.fwd_e_a), 0);

    // clear stall_cnt before md tests
    step(); clr_in(); reset = 1'b0;
    step(); reset = 1'b1;
    settle();
    chk("rst2_cnt", hif.stall_cnt, 0);

    // 4: mult start, dependent held in D
    step();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b0; hif.D_md_use = 1'b1;
    settle();
    chk("t4_stall0", 32'(hif.stall),       1);
    chk("t4_cause0", 32'(hif.stall_cause), 2);
    chk("t4_busy0",  32'(hif.md_busy),     0);
    for (int k = 1; k <= 5; k++) begin
      step(); hif.E_md_start = 1'b0;
      settle();
      chk("t4_busy",  32'(hif.md_busy), 1);
      chk("t4_stall", 32'(hif.stall),   1);
      chk("t4_done",  32'(hif.md_done), (k == 5) ? 32'd1 : 32'd0);
    end
    step();
    settle();
    chk("t4_busy_end",  32'(hif.md_busy), 0);
    chk("t4_stall_end", 32'(hif.stall),   0);
    chk("t4_cnt",       hif.stall_cnt,    6);
    hif.D_md_use = 1'b0;

    // 5: div start, mult restart 3 cycles later
    step();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
    settle();
    chk("t5_err0", 32'(hif.md_err), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      hif.E_md_start = (k == 3); hif.E_md_div = 1'b0;
      settle();
      chk("t5_busy_a", 32'(hif.md_busy), 1);
      chk("t5_err_a",  32'(hif.md_err),  0);
      chk("t5_done_a", 32'(hif.md_done), 0);
    end
    for (int k = 1; k <= 5; k++) begin
      step(); hif.E_md_start = 1'b0;
      settle();
      chk("t5_busy_b", 32'(hif.md_busy), 1);
      chk("t5_err_b",  32'(hif.md_err),  1);
      chk("t5_done_b", 32'(hif.md_done), (k == 5) ? 32'd1 : 32'd0);
    end
    step();
    settle();
    chk("t5_busy_end", 32'(hif.md_busy), 0);
    chk("t5_err_end",  32'(hif.md_err),  1);

    // 6: reset during div busy
    step();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b1; hif.D_md_use = 1'b1;
    step(); hif.E_md_start = 1'b0;
    settle();
    chk("t6_busy",  32'(hif.md_busy), 1);
    chk("t6_cnt",   hif.stall_cnt,    7);
    step(); reset = 1'b0;
    settle();
    chk("t6_busy_inrst", 32'(hif.md_busy), 1);
    step(); reset = 1'b1;
    settle();
    chk("t6_busy_post",  32'(hif.md_busy), 0);
    chk("t6_done_post",  32'(hif.md_done), 0);
    chk("t6_err_post",   32'(hif.md_err),  0);
    chk("t6_cnt_post",   hif.stall_cnt,    0);
    chk("t6_stall_post", 32'(hif.stall),   0);
    for (int k = 0; k < 12; k++) begin
      step();
      settle();
      chk("t6_no_done", 32'(hif.md_done), 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
